fsk_step_sched: RTL and testbench

Binary-FSK symbol scheduler that drives the phase-step input of the modulation-path phase-accumulator signal generator. It accepts data bytes over a valid/ready stream, serialises them LSB-first, and for each bit presents one of two phase increments for exactly `SYM_CYCLES` clocks. It also issues a one-cycle phase-clear at the start of every burst so each burst begins at phase zero. A one-byte holding register lets consecutive bytes go out back-to-back with no gap.

---
 rtl/fsk_step_sched.sv | 171 +++++++++++++++++
 tb/tb_fsk_step_sched.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsk_step_sched.sv
// ---------------------------------------------------------------------------
// fsk_step_sched
// Binary-FSK symbol scheduler feeding the phase-step input of a
// phase-accumulator signal generator. Bytes arrive on a valid/ready stream,
// are serialised LSB-first, and every bit drives one of two phase increments
// for exactly SYM_CYCLES clocks. A one-byte holding register lets consecutive
// bytes go out back-to-back with no gap. Each burst opens with a one-cycle
// phase_clr so the generator starts from phase zero.
//
// Ports
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   in_data      : byte to transmit
//   in_valid     : in_data valid
//   in_ready     : holding register empty (transfer = in_valid && in_ready)
//   abort        : synchronous kill of the current burst and held byte
//   step         : phase increment to the generator, 0 when idle
//   phase_clr    : one-cycle pulse on the first cycle of a burst
//   bit_strobe   : one-cycle pulse on the first cycle of every symbol
//   tx_active    : high while a symbol is being transmitted
// ---------------------------------------------------------------------------
module fsk_step_sched #(
  parameter int                STEP_W     = 24,
  parameter logic [STEP_W-1:0] F0_STEP    = 24'd6698,
  parameter logic [STEP_W-1:0] F1_STEP    = 24'd13396,
  parameter int                SYM_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              abort,
  output logic [STEP_W-1:0] step,
  output logic              phase_clr,
  output logic              bit_strobe,
  output logic              tx_active
);

  localparam int              CNT_W    = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SYM  = 1'b1
  } state_t;

  function automatic logic [STEP_W-1:0] f_step(input logic b);
    return b ? F1_STEP : F0_STEP;
  endfunction

  state_t             r_state,      w_state_nxt;
  logic [7:0]         r_hold,       w_hold_nxt;
  logic               r_hold_full,  w_hold_full_nxt;
  logic [7:0]         r_shreg,      w_shreg_nxt;
  logic [2:0]         r_bit_idx,    w_bit_idx_nxt;
  logic [CNT_W-1:0]   r_sym_cnt,    w_sym_cnt_nxt;
  logic [STEP_W-1:0]  r_step,       w_step_nxt;
  logic               r_phase_clr,  w_phase_clr_nxt;
  logic               r_bit_strobe, w_bit_strobe_nxt;

  logic w_accept;
  logic w_sym_last;

  assign w_accept   = in_valid && !r_hold_full;
  assign w_sym_last = (r_sym_cnt == CNT_LAST);

  // NOTE: every output of this block gets a default first so that no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_hold_nxt       = r_hold;
    w_hold_full_nxt  = r_hold_full;
    w_shreg_nxt      = r_shreg;
    w_bit_idx_nxt    = r_bit_idx;
    w_sym_cnt_nxt    = r_sym_cnt;
    w_step_nxt       = r_step;
    w_phase_clr_nxt  = 1'b0;
    w_bit_strobe_nxt = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_step_nxt = '0;
        if (r_hold_full) begin
          // Start of a burst: the only place phase_clr is raised.
          w_shreg_nxt      = r_hold;
          w_hold_full_nxt  = 1'b0;
          w_bit_idx_nxt    = '0;
          w_sym_cnt_nxt    = '0;
          w_state_nxt      = S_SYM;
          w_step_nxt       = f_step(r_hold[0]);
          w_phase_clr_nxt  = 1'b1;
          w_bit_strobe_nxt = 1'b1;
        end
      end
      S_SYM: begin
        w_sym_cnt_nxt = r_sym_cnt + 1'b1;
        if (w_sym_last) begin
          w_sym_cnt_nxt = '0;
          if (r_bit_idx != 3'd7) begin
            w_bit_idx_nxt    = r_bit_idx + 3'd1;
            w_step_nxt       = f_step(r_shreg[r_bit_idx + 3'd1]);
            w_bit_strobe_nxt = 1'b1;
          end else if (r_hold_full) begin
            // Seamless hand-over to the held byte: no phase_clr, so the
            // generator phase stays continuous across the byte boundary.
            w_shreg_nxt      = r_hold;
            w_hold_full_nxt  = 1'b0;
            w_bit_idx_nxt    = '0;
            w_step_nxt       = f_step(r_hold[0]);
            w_bit_strobe_nxt = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_step_nxt  = '0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Accept after the load so a same-edge accept wins over the clear.
    if (w_accept) begin
      w_hold_nxt      = in_data;
      w_hold_full_nxt = 1'b1;
    end

    // Abort overrides everything, including a transfer in the same cycle.
    if (abort) begin
      w_state_nxt      = S_IDLE;
      w_hold_full_nxt  = 1'b0;
      w_shreg_nxt      = '0;
      w_bit_idx_nxt    = '0;
      w_sym_cnt_nxt    = '0;
      w_step_nxt       = '0;
      w_phase_clr_nxt  = 1'b0;
      w_bit_strobe_nxt = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_shreg      <= '0;
      r_bit_idx    <= '0;
      r_sym_cnt    <= '0;
      r_step       <= '0;
      r_phase_clr  <= 1'b0;
      r_bit_strobe <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold       <= w_hold_nxt;
      r_hold_full  <= w_hold_full_nxt;
      r_shreg      <= w_shreg_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_sym_cnt    <= w_sym_cnt_nxt;
      r_step       <= w_step_nxt;
      r_phase_clr  <= w_phase_clr_nxt;
      r_bit_strobe <= w_bit_strobe_nxt;
    end
  end

  assign in_ready   = !r_hold_full;
  assign step       = r_step;
  assign phase_clr  = r_phase_clr;
  assign bit_strobe = r_bit_strobe;
  assign tx_active  = (r_state == S_SYM);

endmodule

// File: tb/tb_fsk_step_sched.sv
// ---------------------------------------------------------------------------
// tb_fsk_step_sched
// Self-checking bench for fsk_step_sched with SYM_CYCLES = 4. A byte-level
// reference model (one flat cycle counter per byte plus a one-entry hold)
// predicts every output each cycle; a recorder decodes the transmitted bits
// back into bytes so directed scenarios can be pinned to literal values.
// ---------------------------------------------------------------------------
module tb_fsk_step_sched;

  localparam int          N  = 4;
  localparam logic [23:0] F0 = 24'd6698;
  localparam logic [23:0] F1 = 24'd13396;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        abort;
  logic [23:0] step;
  logic        phase_clr;
  logic        bit_strobe;
  logic        tx_active;

  fsk_step_sched #(
    .STEP_W    (24),
    .F0_STEP   (F0),
    .F1_STEP   (F1),
    .SYM_CYCLES(N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .abort     (abort),
    .step      (step),
    .phase_clr (phase_clr),
    .bit_strobe(bit_strobe),
    .tx_active (tx_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_busy, m_hold_full, m_clr, m_acc;
  logic [7:0] m_byte, m_hold;
  int         m_t;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_hold_full = 0; m_clr = 0; m_t = 0;
      m_byte = 8'h00; m_hold = 8'h00;
    end else begin
      m_acc = in_valid && !m_hold_full;
      if (abort) begin
        m_busy = 0; m_hold_full = 0; m_clr = 0; m_t = 0;
      end else begin
        if (m_busy) begin
          if (m_t == 8*N-1) begin
            if (m_hold_full) begin
              m_byte = m_hold; m_hold_full = 0; m_t = 0; m_clr = 0;
            end else begin
              m_busy = 0;
            end
          end else begin
            m_t++;
          end
        end else if (m_hold_full) begin
          m_busy = 1; m_byte = m_hold; m_hold_full = 0; m_t = 0; m_clr = 1;
        end
        if (m_acc) begin
          m_hold = in_data; m_hold_full = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("step",       int'(step),
            m_busy ? int'(m_byte[m_t/N] ? F1 : F0) : 0);
      check("tx_active",  int'(tx_active),  int'(m_busy));
      check("bit_strobe", int'(bit_strobe), int'(m_busy && (m_t % N == 0)));
      check("phase_clr",  int'(phase_clr),  int'(m_busy && m_t == 0 && m_clr));
      check("in_ready",   int'(in_ready),   int'(!m_hold_full));
    end
  end

  // ---------------- recorder ----------------
  int         rec_active, rec_pclr, rec_strobe, rec_pclr_bad, rec_rdy_low;
  int         rec_gaps, rec_last_gap, rec_idle_run, rec_bitcnt;
  bit         rec_seen;
  logic [7:0] rec_cur;
  logic [7:0] rec_bytes[$];
  int         rec_steps[$];

  task automatic rec_clear();
    rec_active = 0; rec_pclr = 0; rec_strobe = 0; rec_pclr_bad = 0;
    rec_rdy_low = 0; rec_gaps = 0; rec_last_gap = 0; rec_idle_run = 0;
    rec_bitcnt = 0; rec_seen = 0; rec_cur = 8'h00;
    rec_bytes.delete(); rec_steps.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (!in_ready) rec_rdy_low++;
      if (phase_clr) rec_pclr++;
      if (phase_clr && !bit_strobe) rec_pclr_bad++;
      if (tx_active) begin
        if (rec_seen && rec_idle_run > 0) begin
          rec_gaps++;
          rec_last_gap = rec_idle_run;
        end
        rec_idle_run = 0;
        rec_seen = 1;
        rec_active++;
      end else if (rec_seen) begin
        rec_idle_run++;
      end
      if (bit_strobe) begin
        rec_strobe++;
        rec_steps.push_back(int'(step));
        rec_cur[rec_bitcnt] = (step == F1);
        rec_bitcnt++;
        if (rec_bitcnt == 8) begin
          rec_bytes.push_back(rec_cur);
          rec_bitcnt = 0;
          rec_cur = 8'h00;
        end
      end
    end
  end

  task automatic check_bytes(input string name, input int n,
                             input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2);
    logic [7:0] e [3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    check({name, "_count"}, rec_bytes.size(), n);
    for (int i = 0; i < n && i < rec_bytes.size(); i++)
      check({name, "_data"}, int'(rec_bytes[i]), int'(e[i]));
  endtask

  // ---------------- drivers ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit keep);
    bit ok;
    ok = 0;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    check("send_ready_seen", int'(ok), 1);
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic pulse_abort(input bit with_valid, input logic [7:0] d);
    abort = 1'b1;
    if (with_valid) begin
      in_valid = 1'b1;
      in_data  = d;
    end
    @(posedge clk);
    #1;
    abort    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  localparam int A5_STEPS [8] = '{F1, F0, F1, F0, F0, F1, F0, F1};

  initial begin
    rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; abort = 1'b0;
    rec_clear();
    wait_cycles(3);
    check("rst_step",       int'(step), 0);
    check("rst_phase_clr",  int'(phase_clr), 0);
    check("rst_bit_strobe", int'(bit_strobe), 0);
    check("rst_tx_active",  int'(tx_active), 0);
    check("rst_in_ready",   int'(in_ready), 1);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    wait_cycles(5);

    // Single byte 0xA5
    rec_clear();
    send_byte(8'hA5, 0);
    wait_cycles(40);
    check_bytes("a5", 1, 8'hA5, 8'h00, 8'h00);
    check("a5_steps_count", rec_steps.size(), 8);
    for (int i = 0; i < 8 && i < rec_steps.size(); i++)
      check("a5_step_seq", rec_steps[i], A5_STEPS[i]);
    check("a5_active", rec_active, 32);
    check("a5_pclr", rec_pclr, 1);
    check("a5_strobes", rec_strobe, 8);
    check("a5_step_after", int'(step), 0);

    // Back-to-back 0x01, 0xFF
    rec_clear();
    send_byte(8'h01, 0);
    send_byte(8'hFF, 0);
    check("b2b_ready_low", int'(in_ready), 0);
    wait_cycles(70);
    check_bytes("b2b", 2, 8'h01, 8'hFF, 8'h00);
    check("b2b_active", rec_active, 64);
    check("b2b_pclr", rec_pclr, 1);
    check("b2b_gaps", rec_gaps, 0);

    // Late arrival on the final cycle of byte 1
    rec_clear();
    send_byte(8'h3C, 0);
    wait_cycles(32);
    send_byte(8'hA6, 0);
    wait_cycles(80);
    check_bytes("late", 2, 8'h3C, 8'hA6, 8'h00);
    check("late_active", rec_active, 64);
    check("late_pclr", rec_pclr, 2);
    check("late_gaps", rec_gaps, 1);
    check("late_gap_len", rec_last_gap, 1);

    // Backpressure: in_valid held high across three bytes
    rec_clear();
    send_byte(8'h11, 1);
    send_byte(8'h96, 1);
    send_byte(8'hE7, 0);
    wait_cycles(110);
    check_bytes("bp", 3, 8'h11, 8'h96, 8'hE7);
    check("bp_active", rec_active, 96);
    check("bp_pclr", rec_pclr, 1);
    check("bp_ready_low_seen", int'(rec_rdy_low > 0), 1);

    // Abort at bit 3 with a byte held
    rec_clear();
    send_byte(8'hC3, 0);
    send_byte(8'h5A, 0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (rec_strobe >= 4) break;
    end
    check("abort_reached_bit3", int'(rec_strobe >= 4), 1);
    @(posedge clk);
    #1;
    pulse_abort(0, 8'h00);
    check("abort_step", int'(step), 0);
    check("abort_tx_active", int'(tx_active), 0);
    check("abort_in_ready", int'(in_ready), 1);
    rec_clear();
    wait_cycles(40);
    check("abort_no_activity", rec_active, 0);
    // A transfer coinciding with abort is discarded.
    pulse_abort(1, 8'h77);
    wait_cycles(40);
    check("abort_xfer_discarded", rec_active, 0);

    // Reset mid-symbol
    send_byte(8'h5F, 0);
    wait_cycles(6);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_step",       int'(step), 0);
    check("mrst_phase_clr",  int'(phase_clr), 0);
    check("mrst_bit_strobe", int'(bit_strobe), 0);
    check("mrst_tx_active",  int'(tx_active), 0);
    check("mrst_in_ready",   int'(in_ready), 1);
    wait_cycles(2);
    rst_n = 1'b1;
    rec_clear();
    wait_cycles(20);
    check("mrst_quiet", rec_active + rec_strobe, 0);

    // Randomized traffic with occasional aborts
    for (int k = 0; k < 40; k++) begin
      send_byte(8'($urandom), 0);
      repeat ($urandom_range(0, 45)) @(posedge clk);
      #1;
      if ($urandom_range(0, 7) == 0)
        pulse_abort(1'($urandom_range(0, 1)), 8'($urandom));
    end
    wait_cycles(80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
